// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program image loader for the core's instruction memory
//
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   start           one-cycle pulse that begins a load (from IDLE, DONE or ERR only)
//   in_valid/data   byte stream in; in_ready out
//   im_wr_en/addr/data  registered instruction-memory write port
//   core_hold       1 keeps the core in reset; drops only after a verified load
//   busy            load in progress
//   load_done/err   sticky result flags, mutually exclusive
//   word_count      words written in the current/last load
//
// Image format: len_lo, len_hi, then len words as (lo, hi) byte pairs, then an
// XOR checksum of all word bytes.

module prog_loader #(
    parameter int D = 10,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         im_wr_en,
    output logic [D-1:0] im_addr,
    output logic [W-1:0] im_data,
    output logic         core_hold,
    output logic         busy,
    output logic         load_done,
    output logic         load_err,
    output logic [D:0]   word_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LEN_LO  = 3'd1;
    localparam logic [2:0] LEN_HI  = 3'd2;
    localparam logic [2:0] WORD_LO = 3'd3;
    localparam logic [2:0] WORD_HI = 3'd4;
    localparam logic [2:0] CHK     = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;
    localparam logic [2:0] ERR     = 3'd7;

    // Largest image that fits the address space; anything above is rejected
    // so the write index can never wrap.
    localparam logic [16:0] MAX_LEN = 17'(2**D);

    // Bits of the high word byte that lie above the W-bit word; they must be zero.
    localparam logic [7:0] HI_MASK = 8'(~((32'd1 << (W - 8)) - 32'd1));

    logic [2:0]   state;
    logic [15:0]  len;
    logic [7:0]   word_lo;
    logic [7:0]   chk;

    logic         accept;
    logic [16:0]  len_full;
    logic [W-1:0] word;
    logic         last_word;
    logic         hi_bad;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            LEN_LO, LEN_HI, WORD_LO, WORD_HI, CHK: in_ready = 1'b1;
            default:                               in_ready = 1'b0;
        endcase
    end

    assign busy      = in_ready;
    assign accept    = in_valid && in_ready;
    assign len_full  = {1'b0, in_data, len[7:0]};
    assign word      = {in_data[W-9:0], word_lo};
    assign hi_bad    = (in_data & HI_MASK) != 8'd0;
    assign last_word = (17'(word_count) + 17'd1) == {1'b0, len};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            len        <= 16'd0;
            word_lo    <= 8'd0;
            chk        <= 8'd0;
            word_count <= '0;
            im_wr_en   <= 1'b0;
            im_addr    <= '0;
            im_data    <= '0;
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse after an accepted high byte.
            im_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        chk        <= 8'd0;
                        word_count <= '0;
                        state      <= LEN_LO;
                    end
                end
                DONE, ERR: begin
                    if (start) begin
                        load_done  <= 1'b0;
                        load_err   <= 1'b0;
                        word_count <= '0;
                        chk        <= 8'd0;
                        core_hold  <= 1'b1;
                        state      <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= in_data;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= in_data;
                        if (len_full == 17'd0) begin
                            state <= CHK;
                        end else if (len_full > MAX_LEN) begin
                            load_err <= 1'b1;
                            state    <= ERR;
                        end else begin
                            state <= WORD_LO;
                        end
                    end
                end
                WORD_LO: begin
                    if (accept) begin
                        word_lo <= in_data;
                        chk     <= chk ^ in_data;
                        state   <= WORD_HI;
                    end
                end
                WORD_HI: begin
                    if (accept) begin
                        if (hi_bad) begin
                            load_err <= 1'b1;
                            state    <= ERR;
                        end else begin
                            im_wr_en   <= 1'b1;
                            im_addr    <= word_count[D-1:0];
                            im_data    <= word;
                            word_count <= word_count + 1'b1;
                            chk        <= chk ^ in_data;
                            state      <= last_word ? CHK : WORD_LO;
                        end
                    end
                end
                CHK: begin
                    if (accept) begin
                        if (in_data == chk) begin
                            load_done <= 1'b1;
                            core_hold <= 1'b0;
                            state     <= DONE;
                        end else begin
                            load_err <= 1'b1;
                            state    <= ERR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader

module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       im_wr_en;
    logic [9:0] im_addr;
    logic [8:0] im_data;
    logic       core_hold;
    logic       busy;
    logic       load_done;
    logic       load_err;
    logic [10:0] word_count;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    int pulses_before;

    always #5 clk = ~clk;

    prog_loader #(.D(10), .W(9)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .im_wr_en   (im_wr_en),
        .im_addr    (im_addr),
        .im_data    (im_data),
        .core_hold  (core_hold),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always @(negedge clk) begin
        if (im_wr_en === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; leaves the bench in the same phase.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit exp_wr,
                        input logic [9:0] ea, input logic [8:0] ed, input bit gaps);
        int n;
        bit ok;
        if (gaps) begin
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = (in_ready === 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
        end
        check("im_wr_en", {31'd0, im_wr_en}, {31'd0, exp_wr});
        if (exp_wr) begin
            check("im_addr", {22'd0, im_addr}, {22'd0, ea});
            check("im_data", {23'd0, im_data}, {23'd0, ed});
        end
    endtask

    task automatic run_test1(input bit gaps, input logic [7:0] last);
        send(8'h03, 1'b0, 10'd0, 9'h000, gaps);
        send(8'h00, 1'b0, 10'd0, 9'h000, gaps);
        send(8'hA5, 1'b0, 10'd0, 9'h000, gaps);
        send(8'h01, 1'b1, 10'd0, 9'h1A5, gaps);
        send(8'h00, 1'b0, 10'd0, 9'h000, gaps);
        send(8'h00, 1'b1, 10'd1, 9'h000, gaps);
        send(8'hFF, 1'b0, 10'd0, 9'h000, gaps);
        send(8'h00, 1'b1, 10'd2, 9'h0FF, gaps);
        send(last,  1'b0, 10'd0, 9'h000, gaps);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_core_hold", {31'd0, core_hold}, 32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_done",      {31'd0, load_done}, 32'd0);
        check("rst_err",       {31'd0, load_err},  32'd0);
        check("rst_wc",        {21'd0, word_count}, 32'd0);
        check("rst_wr_en",     {31'd0, im_wr_en},  32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Valid 3-word image
        pulse_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        pulses_before = pulses;
        run_test1(1'b0, 8'h5B);
        check("t1_done",     {31'd0, load_done}, 32'd1);
        check("t1_err",      {31'd0, load_err},  32'd0);
        check("t1_hold",     {31'd0, core_hold}, 32'd0);
        check("t1_wc",       {21'd0, word_count}, 32'd3);
        check("t1_in_ready", {31'd0, in_ready},  32'd0);
        check("t1_pulses",   pulses - pulses_before, 32'd3);

        // Bad checksum; restart from DONE clears flags
        pulse_start();
        check("t2_done_clr", {31'd0, load_done}, 32'd0);
        check("t2_hold_set", {31'd0, core_hold}, 32'd1);
        check("t2_wc_clr",   {21'd0, word_count}, 32'd0);
        pulses_before = pulses;
        run_test1(1'b0, 8'h5C);
        check("t2_err",    {31'd0, load_err},  32'd1);
        check("t2_done",   {31'd0, load_done}, 32'd0);
        check("t2_hold",   {31'd0, core_hold}, 32'd1);
        check("t2_pulses", pulses - pulses_before, 32'd3);

        // Empty image, good then bad checksum
        pulse_start();
        check("t3_err_clr", {31'd0, load_err}, 32'd0);
        pulses_before = pulses;
        send(8'h00, 1'b0, 10'd0, 9'h000, 1'b0);
        send(8'h00, 1'b0, 10'd0, 9'h000, 1'b0);
        send(8'h00, 1'b0, 10'd0, 9'h000, 1'b0);
        check("t3_done",   {31'd0, load_done}, 32'd1);
        check("t3_wc",     {21'd0, word_count}, 32'd0);
        check("t3_hold",   {31'd0, core_hold}, 32'd0);
        check("t3_pulses", pulses - pulses_before, 32'd0);
        pulse_start();
        send(8'h00, 1'b0, 10'd0, 9'h000, 1'b0);
        send(8'h00, 1'b0, 10'd0, 9'h000, 1'b0);
        send(8'h01, 1'b0, 10'd0, 9'h000, 1'b0);
        check("t3b_err",  {31'd0, load_err},  32'd1);
        check("t3b_done", {31'd0, load_done}, 32'd0);

        // Oversize length 1025
        pulse_start();
        pulses_before = pulses;
        send(8'h01, 1'b0, 10'd0, 9'h000, 1'b0);
        send(8'h04, 1'b0, 10'd0, 9'h000, 1'b0);
        check("t4_err",      {31'd0, load_err}, 32'd1);
        check("t4_in_ready", {31'd0, in_ready}, 32'd0);
        check("t4_hold",     {31'd0, core_hold}, 32'd1);
        @(posedge clk); #1;
        check("t4_pulses",   pulses - pulses_before, 32'd0);

        // Illegal high byte
        pulse_start();
        pulses_before = pulses;
        send(8'h02, 1'b0, 10'd0, 9'h000, 1'b0);
        send(8'h00, 1'b0, 10'd0, 9'h000, 1'b0);
        send(8'h11, 1'b0, 10'd0, 9'h000, 1'b0);
        send(8'h03, 1'b0, 10'd0, 9'h000, 1'b0);
        check("t5_err",    {31'd0, load_err},  32'd1);
        check("t5_wc",     {21'd0, word_count}, 32'd0);
        @(posedge clk); #1;
        check("t5_pulses", pulses - pulses_before, 32'd0);

        // Backpressure with random gaps
        pulse_start();
        pulses_before = pulses;
        run_test1(1'b1, 8'h5B);
        check("t6_done",   {31'd0, load_done}, 32'd1);
        check("t6_hold",   {31'd0, core_hold}, 32'd0);
        check("t6_wc",     {21'd0, word_count}, 32'd3);
        check("t6_pulses", pulses - pulses_before, 32'd3);

        // Mid-load start ignored, then reset after two words
        pulse_start();
        send(8'h03, 1'b0, 10'd0, 9'h000, 1'b0);
        send(8'h00, 1'b0, 10'd0, 9'h000, 1'b0);
        send(8'hA5, 1'b0, 10'd0, 9'h000, 1'b0);
        send(8'h01, 1'b1, 10'd0, 9'h1A5, 1'b0);
        pulse_start();
        check("t7_busy_after_start", {31'd0, busy}, 32'd1);
        send(8'h00, 1'b0, 10'd0, 9'h000, 1'b0);
        send(8'h00, 1'b1, 10'd1, 9'h000, 1'b0);
        check("t7_wc_mid", {21'd0, word_count}, 32'd2);
        reset = 1'b0;
        #1;
        check("t7_rst_hold", {31'd0, core_hold}, 32'd1);
        check("t7_rst_busy", {31'd0, busy},      32'd0);
        check("t7_rst_done", {31'd0, load_done}, 32'd0);
        check("t7_rst_err",  {31'd0, load_err},  32'd0);
        check("t7_rst_wc",   {21'd0, word_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t7_idle_ready", {31'd0, in_ready}, 32'd0);
        pulse_start();
        pulses_before = pulses;
        run_test1(1'b0, 8'h5B);
        check("t7_done",   {31'd0, load_done}, 32'd1);
        check("t7_hold",   {31'd0, core_hold}, 32'd0);
        check("t7_wc",     {21'd0, word_count}, 32'd3);
        check("t7_pulses", pulses - pulses_before, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
